// File: rtl/dmem_dual_issue_arbiter.sv
// Serialises the lane-1/lane-2 memory pair of a dual-issue bundle onto one
// single-port data-memory backend. Optional store-to-load forwarding: DMEM_ARB_FWD_EN.
module dmem_dual_issue_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              req2,
    input  logic              we2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata2,
    output logic              stall,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid2,
    output logic [DATA_W-1:0] rdata2,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L1   = 2'd1,
        L2   = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } lane_t;

    state_e            state_q, state_d;
    lane_t             lane1_q, lane1_d;
    lane_t             lane2_q, lane2_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic              rvalid1_q, rvalid1_d;
    logic              rvalid2_q, rvalid2_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              xfer;
    logic              fwd_hit;

    assign xfer = mem_req_q && mem_ready;

    // Lane-2 load of the address lane 1 just stored is served from the latched store data.
`ifdef DMEM_ARB_FWD_EN
    assign fwd_hit = lane1_q.req && lane1_q.we && lane2_q.req && !lane2_q.we
                     && (lane1_q.addr == lane2_q.addr);
`else
    assign fwd_hit = 1'b0;
`endif

    // Next state, pair capture and load-data capture.
    always_comb begin
        state_d  = state_q;
        lane1_d  = lane1_q;
        lane2_d  = lane2_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        case (state_q)
            IDLE: begin
                if ((req1 == 1'b1) || (req2 == 1'b1)) begin
                    state_d = (req1 == 1'b1) ? L1 : L2;
                    lane1_d = '{req: (req1 == 1'b1), we: we1, addr: addr1, wdata: wdata1};
                    lane2_d = '{req: (req2 == 1'b1), we: we2, addr: addr2, wdata: wdata2};
                end
            end
            L1: begin
                if (xfer) begin
                    if (!lane1_q.we) begin
                        rdata1_d = mem_rdata;
                    end
                    if (fwd_hit) begin
                        rdata2_d = lane1_q.wdata;
                        state_d  = DONE;
                    end else begin
                        state_d = lane2_q.req ? L2 : DONE;
                    end
                end
            end
            L2: begin
                if (xfer) begin
                    if (!lane2_q.we) begin
                        rdata2_d = mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        rvalid1_d   = (state_d == DONE) && lane1_d.req && !lane1_d.we;
        rvalid2_d   = (state_d == DONE) && lane2_d.req && !lane2_d.we;
        case (state_d)
            L1: begin
                mem_req_d   = 1'b1;
                mem_we_d    = lane1_d.we;
                mem_addr_d  = lane1_d.addr;
                mem_wdata_d = lane1_d.wdata;
            end
            L2: begin
                mem_req_d   = 1'b1;
                mem_we_d    = lane2_d.we;
                mem_addr_d  = lane2_d.addr;
                mem_wdata_d = lane2_d.wdata;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= IDLE;
            lane1_q     <= '0;
            lane2_q     <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            rvalid1_q   <= 1'b0;
            rvalid2_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lane1_q     <= lane1_d;
            lane2_q     <= lane2_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            rvalid1_q   <= rvalid1_d;
            rvalid2_q   <= rvalid2_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Stall depends only on state and the core's requests, never on mem_ready.
    assign stall = !RESET && (((state_q == IDLE) && (req1 || req2))
                              || (state_q == L1) || (state_q == L2));

    assign rvalid1   = rvalid1_q;
    assign rdata1    = rdata1_q;
    assign rvalid2   = rvalid2_q;
    assign rdata2    = rdata2_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_dual_issue_arbiter.sv
// Directed bench for dmem_dual_issue_arbiter with a small wait-state-capable memory model.
module tb_dmem_dual_issue_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic          req1, we1, req2, we2;
    logic [AW-1:0] addr1, addr2;
    logic [DW-1:0] wdata1, wdata2;
    logic          stall, rvalid1, rvalid2;
    logic [DW-1:0] rdata1, rdata2;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 CLOCK = ~CLOCK;

    dmem_dual_issue_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .req2(req2), .we2(we2), .addr2(addr2), .wdata2(wdata2),
        .stall(stall), .rvalid1(rvalid1), .rdata1(rdata1),
        .rvalid2(rvalid2), .rdata2(rdata2),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Memory model: 256 words, programmable wait states, preload port.
    logic [DW-1:0] mem [256];
    int            wcnt;
    int            wait_cfg;
    logic          hold_ready;
    logic          pl_en, clr_en;
    logic [7:0]    pl_addr;
    logic [DW-1:0] pl_data;

    assign mem_ready = !hold_ready && (wcnt >= wait_cfg);
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge CLOCK) begin
        if (clr_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge CLOCK); #1;
        pl_en = 1'b0;
    endtask

    // Results of the last transaction run.
    int            t_stall, t_xfers, t_rv1, t_rv2, t_nreq, t_donek;
    logic          t_done, t_after;
    logic [DW-1:0] t_rd1, t_rd2;
    logic [AW-1:0] t_xaddr [4];
    logic          t_xwe   [4];
    logic [DW-1:0] t_xwd   [4];
    logic [AW-1:0] t_reqaddr [16];

    // Called at posedge+1 with requests set; releases them once stall drops.
    task automatic run_txn();
        t_stall = 0; t_xfers = 0; t_rv1 = 0; t_rv2 = 0; t_nreq = 0;
        t_done = 1'b0; t_donek = -1; t_rd1 = '0; t_rd2 = '0;
        for (int k = 0; k < 60 && !t_done; k++) begin
            @(negedge CLOCK);
            if (stall) t_stall++;
            if (mem_req && t_nreq < 16) begin
                t_reqaddr[t_nreq] = mem_addr;
                t_nreq++;
            end
            if (mem_req && mem_ready && t_xfers < 4) begin
                t_xaddr[t_xfers] = mem_addr;
                t_xwe[t_xfers]   = mem_we;
                t_xwd[t_xfers]   = mem_wdata;
                t_xfers++;
            end
            if (rvalid1) begin t_rv1++; t_rd1 = rdata1; end
            if (rvalid2) begin t_rv2++; t_rd2 = rdata2; end
            if (!stall && k > 0) begin
                t_done = 1'b1; t_donek = k;
                req1 = 1'b0; req2 = 1'b0;
            end
        end
        check("txn_timeout", 64'(t_done), 64'd1);
        req1 = 1'b0; req2 = 1'b0;
        @(negedge CLOCK);
        t_after = rvalid1 || rvalid2 || stall;
        @(posedge CLOCK); #1;
    endtask

    task automatic set_lanes(input logic r1, input logic w1, input logic [AW-1:0] a1,
                             input logic [DW-1:0] d1, input logic r2, input logic w2,
                             input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        req2 = r2; we2 = w2; addr2 = a2; wdata2 = d2;
    endtask

    int cnt_a, cnt_b;

    initial begin
        RESET = 1'b1; hold_ready = 1'b0; wait_cfg = 0; pl_en = 1'b0; clr_en = 1'b1;
        pl_addr = '0; pl_data = '0;
        set_lanes(1'b1, 1'b0, 64'h10, '0, 1'b1, 1'b0, 64'h18, '0);
        @(posedge CLOCK); #1;
        clr_en = 1'b0;
        @(negedge CLOCK);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_rvalid", 64'({rvalid1, rvalid2}), 64'd0);
        @(posedge CLOCK); #1;
        preload(8'h10, 64'hAB);
        preload(8'h08, 64'h1111);
        preload(8'h18, 64'h2222);
        preload(8'h30, 64'h11);
        set_lanes(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        RESET = 1'b0;
        @(posedge CLOCK); #1;
        @(negedge CLOCK);
        check("post_rst_stall", 64'(stall), 64'd0);
        check("post_rst_mem_req", 64'(mem_req), 64'd0);
        check("post_rst_rdata", rdata1 | rdata2, 64'd0);
        check("post_rst_addr", mem_addr, 64'd0);
        @(posedge CLOCK); #1;

        // Single load, zero-wait backend.
        set_lanes(1'b1, 1'b0, 64'h10, '0, 1'b0, 1'b0, '0, '0);
        run_txn();
        check("ld_stall", 64'(t_stall), 64'd2);
        check("ld_donek", 64'(t_donek), 64'd2);
        check("ld_xfers", 64'(t_xfers), 64'd1);
        check("ld_addr", t_xaddr[0], 64'h10);
        check("ld_req_cycles", 64'(t_nreq), 64'd1);
        check("ld_rv1", 64'(t_rv1), 64'd1);
        check("ld_rd1", t_rd1, 64'hAB);
        check("ld_rv2", 64'(t_rv2), 64'd0);
        check("ld_pulse_end", 64'(t_after), 64'd0);

        // Store then load, same address.
        set_lanes(1'b1, 1'b1, 64'h20, 64'h55, 1'b1, 1'b0, 64'h20, '0);
        run_txn();
        check("sl_xaddr0", t_xaddr[0], 64'h20);
        check("sl_xwe0", 64'(t_xwe[0]), 64'd1);
        check("sl_xwd0", t_xwd[0], 64'h55);
`ifdef DMEM_ARB_FWD_EN
        check("sl_stall", 64'(t_stall), 64'd2);
        check("sl_xfers", 64'(t_xfers), 64'd1);
`else
        check("sl_stall", 64'(t_stall), 64'd3);
        check("sl_xfers", 64'(t_xfers), 64'd2);
        check("sl_xaddr1", t_xaddr[1], 64'h20);
        check("sl_xwe1", 64'(t_xwe[1]), 64'd0);
`endif
        check("sl_rv2", 64'(t_rv2), 64'd1);
        check("sl_rd2", t_rd2, 64'h55);
        check("sl_rv1", 64'(t_rv1), 64'd0);
        check("sl_mem", mem[8'h20], 64'h55);

        // Pair of loads with two wait states per access.
        wait_cfg = 2;
        set_lanes(1'b1, 1'b0, 64'h08, '0, 1'b1, 1'b0, 64'h18, '0);
        run_txn();
        wait_cfg = 0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < t_nreq && i < 16; i++) begin
            if (i < 3 && t_reqaddr[i] == 64'h08) cnt_a++;
            if (i >= 3 && t_reqaddr[i] == 64'h18) cnt_b++;
        end
        check("ws_stall", 64'(t_stall), 64'd7);
        check("ws_xfers", 64'(t_xfers), 64'd2);
        check("ws_req_cycles", 64'(t_nreq), 64'd6);
        check("ws_hold_a1", 64'(cnt_a), 64'd3);
        check("ws_hold_a2", 64'(cnt_b), 64'd3);
        check("ws_rd1", t_rd1, 64'h1111);
        check("ws_rd2", t_rd2, 64'h2222);

        // Lane-2-only store.
        set_lanes(1'b0, 1'b0, 64'h99, 64'h99, 1'b1, 1'b1, 64'h40, 64'h77);
        run_txn();
        check("l2s_stall", 64'(t_stall), 64'd2);
        check("l2s_xfers", 64'(t_xfers), 64'd1);
        check("l2s_addr", t_xaddr[0], 64'h40);
        check("l2s_we", 64'(t_xwe[0]), 64'd1);
        check("l2s_wd", t_xwd[0], 64'h77);
        check("l2s_rv", 64'(t_rv1 + t_rv2), 64'd0);
        check("l2s_mem", mem[8'h40], 64'h77);

        // Load then store, same address: lane 1 sees the old value.
        set_lanes(1'b1, 1'b0, 64'h30, '0, 1'b1, 1'b1, 64'h30, 64'h22);
        run_txn();
        check("ls_stall", 64'(t_stall), 64'd3);
        check("ls_rd1", t_rd1, 64'h11);
        check("ls_rv2", 64'(t_rv2), 64'd0);
        check("ls_mem", mem[8'h30], 64'h22);

        // Store then store, same address: lane 2 wins.
        set_lanes(1'b1, 1'b1, 64'h50, 64'hA1, 1'b1, 1'b1, 64'h50, 64'hB2);
        run_txn();
        check("ss_xfers", 64'(t_xfers), 64'd2);
        check("ss_mem", mem[8'h50], 64'hB2);

        // Reset while lane 2 waits on the backend.
        set_lanes(1'b1, 1'b0, 64'h08, '0, 1'b1, 1'b0, 64'h18, '0);
        @(posedge CLOCK); #1;
        @(posedge CLOCK); #1;
        hold_ready = 1'b1;
        @(negedge CLOCK);
        check("mid_l2_req", 64'(mem_req), 64'd1);
        check("mid_l2_addr", mem_addr, 64'h18);
        check("mid_l2_stall", 64'(stall), 64'd1);
        check("mid_l2_rd1", rdata1, 64'h1111);
        RESET = 1'b1;
        set_lanes(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge CLOCK);
        check("mid_rst_req", 64'(mem_req), 64'd0);
        check("mid_rst_stall", 64'(stall), 64'd0);
        check("mid_rst_rv", 64'({rvalid1, rvalid2}), 64'd0);
        check("mid_rst_rd1", rdata1, 64'd0);
        check("mid_rst_addr", mem_addr, 64'd0);
        RESET = 1'b0; hold_ready = 1'b0;
        @(posedge CLOCK); #1;
        @(negedge CLOCK);
        check("mid_after_rv", 64'({rvalid1, rvalid2, mem_req}), 64'd0);
        @(posedge CLOCK); #1;
        set_lanes(1'b1, 1'b0, 64'h18, '0, 1'b1, 1'b0, 64'h10, '0);
        run_txn();
        check("rec_stall", 64'(t_stall), 64'd3);
        check("rec_rd1", t_rd1, 64'h2222);
        check("rec_rd2", t_rd2, 64'hAB);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
